// File: rtl/mux_ctrl_pkg.sv
// Shared types, sizes and the round-robin pick helper for the 8-way mux arbiter.
// Pure declarations: no state, no timing.
package mux_ctrl_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {IDLE, GRANT} state_t;

    // Returns {found, index}: first set bit of req scanning start, start+1, ... mod N_REQ.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] index;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        index = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
        return {found, index};
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the mux arbiter.
// The arbiter sits on the slave side; requesters drive req/last from the master side.
interface mux8_rr_arbiter_if;
    import mux_ctrl_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] last;
    logic [SEL_W-1:0] Select;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             preempt;

    modport master (output req, output last,
                    input Select, input grant, input busy, input preempt);

    modport slave  (input req, input last,
                    output Select, output grant, output busy, output preempt);

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational 8-way rotate-and-priority-encode; zero latency.
// No flow control: result follows the inputs within the same cycle.
module rr_priority_pick
    import mux_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] index
);

    assign {found, index} = rr_pick(req, start);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the shared 8:1 datapath mux; grant one cycle after req, back-to-back handover.
// Tenure ends on owner last, owner dropping req, or the MAX_HOLD limit (preempt pulse).
module mux8_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mux8_rr_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic [N_REQ-1:0] pick_req;
    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    logic own_req;
    logic rel_normal;
    logic at_limit;
    logic release_now;

    assign own_req     = bus.req[owner_q];
    assign rel_normal  = own_req & bus.last[owner_q];
    assign at_limit    = (hold_q == HOLD_LIM);
    assign release_now = rel_normal | ~own_req | at_limit;

    // One picker serves both searches: from ptr when idle, from owner+1 with the owner masked on handover.
    always_comb begin
        pick_req   = bus.req;
        pick_start = ptr_q;
        if (state_q == GRANT) begin
            pick_req   = bus.req & ~grant_q;
            pick_start = owner_q + SEL_W'(1);
        end
    end

    rr_priority_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = GRANT;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    hold_d            = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d     = owner_q + SEL_W'(1);
                    preempt_d = at_limit & ~rel_normal;
                    if (pick_found) begin
                        owner_d           = pick_idx;
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        hold_d            = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // Select tracks the current or most recent owner, so it simply mirrors owner_q.
    assign bus.grant   = grant_q;
    assign bus.Select  = owner_q;
    assign bus.busy    = (state_q == GRANT);
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a behavioural ownership model and per-cycle compare.
module tb_mux8_rr_arbiter;
    import mux_ctrl_pkg::*;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset;

    mux8_rr_arbiter_if bus ();

    mux8_rr_arbiter #(.MAX_HOLD(HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Model: who owns the mux, how long they have held it, and where the next search starts.
    bit         m_busy  = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_hold  = 0;
    bit         m_pre   = 0;
    int         m_win;
    bit         m_normal;
    logic [7:0] m_mask;
    logic [7:0] exp_grant;

    function automatic int search(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_pre   = 0;
        end else begin
            m_pre = 0;
            if (!m_busy) begin
                m_win = search(bus.req, m_ptr);
                if (m_win >= 0) begin
                    m_busy  = 1;
                    m_owner = m_win;
                    m_hold  = 1;
                end
            end else begin
                m_normal = bus.req[m_owner] && bus.last[m_owner];
                if (m_normal || !bus.req[m_owner] || m_hold == HOLD) begin
                    m_pre  = !m_normal && (m_hold == HOLD);
                    m_ptr  = (m_owner + 1) % 8;
                    m_mask = bus.req;
                    m_mask[m_owner] = 1'b0;
                    m_win  = search(m_mask, m_ptr);
                    if (m_win >= 0) begin
                        m_owner = m_win;
                        m_hold  = 1;
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_hold++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_grant = m_busy ? (8'h01 << m_owner) : 8'h00;
            chk("cyc_grant",   32'(bus.grant),   32'(exp_grant));
            chk("cyc_select",  32'(bus.Select),  32'(m_owner % 8));
            chk("cyc_busy",    32'(bus.busy),    32'(m_busy));
            chk("cyc_preempt", 32'(bus.preempt), 32'(m_pre));
            chk("cyc_onehot",  32'($countones(bus.grant) <= 1 &&
                               (bus.grant == 8'h00 || bus.grant == (8'h01 << bus.Select))), 32'd1);
        end
    end

    task automatic step(input logic [7:0] r, input logic [7:0] l);
        bus.req  = r;
        bus.last = l;
        @(posedge clk);
        #1;
    endtask

    int         order [6] = '{3, 7, 0, 3, 7, 0};
    logic [7:0] one8 = 8'h01;

    initial begin
        reset    = 1'b1;
        bus.req  = 8'h00;
        bus.last = 8'h00;
        step(8'h00, 8'h00);
        chk_en = 1;
        step(8'h00, 8'h00);
        chk("rst_grant",   32'(bus.grant),   32'h0);
        chk("rst_select",  32'(bus.Select),  32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_preempt", 32'(bus.preempt), 32'h0);
        reset = 1'b0;

        // Single requester 2, last on its third grant cycle.
        step(8'h04, 8'h00);
        chk("r2_grant1",  32'(bus.grant),  32'h04);
        chk("r2_select1", 32'(bus.Select), 32'd2);
        step(8'h04, 8'h00);
        step(8'h04, 8'h00);
        chk("r2_grant3",  32'(bus.grant),  32'h04);
        step(8'h04, 8'h04);
        chk("r2_idle",    32'(bus.grant),  32'h00);
        chk("r2_sel_hold", 32'(bus.Select), 32'd2);

        // Constant 1000_1001 with immediate last: rotation starts at ptr=3.
        for (int k = 0; k < 6; k++) begin
            step(8'h89, 8'h89);
            chk("rr_order", 32'(bus.grant), 32'(one8 << order[k]));
            chk("rr_busy",  32'(bus.busy),  32'd1);
        end
        step(8'h00, 8'h00);

        // Hold limit: owner 5 preempted after 4 cycles in favour of 1.
        step(8'h20, 8'h00);
        chk("hl_own5_1", 32'(bus.grant), 32'h20);
        for (int k = 0; k < 3; k++) begin
            step(8'h22, 8'h00);
            chk("hl_own5", 32'(bus.grant), 32'h20);
        end
        step(8'h22, 8'h00);
        chk("hl_grant1",  32'(bus.grant),   32'h02);
        chk("hl_preempt", 32'(bus.preempt), 32'd1);
        step(8'h22, 8'h00);
        chk("hl_pre_once", 32'(bus.preempt), 32'd0);
        step(8'h22, 8'h02);
        chk("hl_back5", 32'(bus.grant), 32'h20);
        step(8'h00, 8'h00);
        chk("hl_idle_sel", 32'(bus.Select), 32'd5);

        // Owner 6 abandons mid-tenure.
        step(8'h40, 8'h00);
        step(8'h40, 8'h00);
        step(8'h00, 8'h00);
        chk("ab_grant",   32'(bus.grant),   32'h00);
        chk("ab_busy",    32'(bus.busy),    32'd0);
        chk("ab_select",  32'(bus.Select),  32'd6);
        chk("ab_preempt", 32'(bus.preempt), 32'd0);

        // Reset in the second cycle of owner 4's tenure.
        step(8'h10, 8'h00);
        chk("mr_own4", 32'(bus.grant), 32'h10);
        step(8'h10, 8'h00);
        reset = 1'b1;
        step(8'h10, 8'h00);
        chk("mr_grant",  32'(bus.grant),  32'h00);
        chk("mr_select", 32'(bus.Select), 32'd0);
        chk("mr_busy",   32'(bus.busy),   32'd0);
        reset = 1'b0;
        step(8'hFF, 8'h00);
        chk("mr_first0", 32'(bus.grant), 32'h01);

        // Non-owner last ignored; last coinciding with the hold limit is a normal release.
        step(8'hFF, 8'hFE);
        chk("nl_hold", 32'(bus.grant), 32'h01);
        step(8'hFF, 8'hFE);
        step(8'hFF, 8'hFE);
        chk("nl_hold4", 32'(bus.grant), 32'h01);
        step(8'hFF, 8'hFF);
        chk("co_grant",   32'(bus.grant),   32'h02);
        chk("co_preempt", 32'(bus.preempt), 32'd0);
        step(8'h00, 8'h00);
        chk("co_idle", 32'(bus.busy), 32'd0);

        step(8'h00, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-input 32-bit datapath multiplexer among 8 requesters.
- Drives the mux 3-bit Select and a one-hot grant, and holds ownership for a multi-cycle transfer until the owner signals last.
- Bounds each tenure with a hold limit so that no requester can starve the others.
- Sits between the requesting units (PC sources, ALU result, memory data, shifter, mul/div and so on) and the shared mux.

Parameters:
- MAX_HOLD, 16: maximum cycles one owner may keep the grant; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request per requester; must stay high for the whole transfer.
- last  input  8  final-cycle marker per requester; sampled only for the current owner.
- Select  output  3  mux select = index of the current or most recent owner; registered.
- grant  output  8  one-hot grant, all zero when idle; registered.
- busy  output  1  high while in GRANT state.
- preempt  output  1  one-cycle pulse when a tenure is ended by the hold limit.

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, grant=0, Select=0, busy=0, preempt=0, ptr=0, owner=0, hold_cnt=0.
- Reset asserted in any state (including mid-transfer) takes effect at the next edge. grant drops with no completion pulse.
- State IDLE:
  - If req!=0, winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: state=GRANT, owner=winner, grant=onehot(winner), Select=winner, hold_cnt=1.
  - Latency from req to grant is 1 cycle.
  - If req==0, stay in IDLE. Select holds its last value and grant=0.
- State GRANT (owner o). Release occurs on the current cycle if any of the following is true:
  - (a) req[o]=1 and last[o]=1: normal end; that cycle is the final transfer cycle.
  - (b) req[o]=0: abandoned.
  - (c) hold_cnt==MAX_HOLD and not (a): preempt.
- Otherwise: hold_cnt increments and grant/Select stay unchanged.
- On release, ptr <= o+1 (mod 8, wraps 7->0). Next winner is searched from o+1 over req with bit o masked:
  - A winner exists: back-to-back handover with no idle cycle; grant/Select switch at the next edge and hold_cnt=1.
  - No winner: state=IDLE and grant=0 at the next edge.
- The releasing owner is masked for one cycle only. If it still requests, it competes again from IDLE with lowest priority.
- preempt=1 for exactly the cycle after case (c). When (a) and (c) coincide, case (a) wins and preempt=0.
- last on non-owner lines is ignored. A req rise during another tenure is queued implicitly and never changes the current grant.
- With MAX_HOLD=1, every tenure lasts one cycle and preempt pulses unless last is also set.
- hold_cnt never exceeds MAX_HOLD, so the counter cannot overflow.
- Invariants: popcount(grant)<=1. When grant!=0, grant==onehot(Select).

Decomposition:
- Shared package mux_ctrl_pkg holds:
  - state typedef {IDLE, GRANT};
  - constants N_REQ=8 and SEL_W=3;
  - function rr_pick(req, start) returning {found, index}.
- One sub-module, rr_priority_pick: combinational 8-way rotate-and-priority-encode. It is used for both the IDLE and the handover search.

Test Plan:
- Reset, then req=8'b0000_0100 held with last asserted on its 3rd grant cycle -> grant=0000_0100 and Select=2 one cycle after req, for 3 cycles. Then idle and ptr=3.
- After that, req=8'b1000_1001 constant, each owner asserting last on its first cycle -> grant order 3,7,0,3,7,0 with no idle cycles between owners.
- MAX_HOLD=4, req[5] held, last never set, req[1] also high -> owner 5 for 4 cycles, preempt pulses once, then owner 1. Owner 5 is regranted only after owner 1 releases.
- Owner 6 drops req[6] mid-tenure with no other request -> next edge grant=0, busy=0, Select stays 6, preempt=0.
- Reset asserted in the 2nd cycle of a tenure by requester 4 -> next edge grant=0, Select=0, busy=0. With req=8'hFF after reset, the first grant goes to requester 0.
- Simultaneous last[o] and hold_cnt==MAX_HOLD -> normal release with preempt=0. last pulses on non-owner lines have no effect on grant.
